dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the processor's single-port 256x8 data memory. It shares the memory between the pipeline's EX-stage load/store port (requester 0) and an external loader/debug port (requester 1). It uses round-robin arbitration, valid/ready request handshakes and registered single-cycle response pulses. It also produces the stall signal the pipeline uses to hold EX while its access is pending.

## Interface
- AW, 8, memory address width
- DW, 8, memory data width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0_valid, req1_valid  in  1  requester i has a command
- req0_we, req1_we  in  1  1 = write, 0 = read
- req0_addr, req1_addr  in  AW  byte address
- req0_wdata, req1_wdata  in  DW  write data
- req0_ready, req1_ready  out  1  command accepted this cycle (valid & ready = handshake)
- rsp0_valid, rsp1_valid  out  1  one-cycle completion pulse
- rsp0_rdata, rsp1_rdata  out  DW  read data; 0 for writes; held until next response on that port
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  registered
- mem_wdata  out  DW  registered
- mem_rdata  in  DW  read data, valid the cycle after mem_en & ~mem_we
- cpu_stall  out  1  req0_valid & ~req0_ready, combinational
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: accepts one command.
  - CMD: mem_en=1 for exactly one cycle, with the captured we/addr/wdata.
  - WAIT: samples mem_rdata at the end of the cycle.
  - WAIT always returns to IDLE.
- Arbitration, in IDLE only:
  - Exactly one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - Pointer last_grant resets to 1, so requester 0 wins the first tie.
  - The pointer updates only on a handshake.
- ready is combinational: reqi_ready = (state==IDLE) & reset & win_i. At most one ready is high per cycle. Both readys are 0 in CMD and WAIT.
- On handshake the block captures we/addr/wdata and the winner id into internal registers. Requester inputs are don't-care after the handshake.
- A requester may drop valid before ready; no state is kept for it.
- Response: in the cycle after WAIT, rsp<id>_valid=1 for one cycle.
  - Read: rsp<id>_rdata is loaded with the value mem_rdata had in WAIT.
  - Write: rsp<id>_rdata is loaded with 0.
  - The other port's rsp signals are unchanged.
- No address arithmetic; addr is passed through unmodified (full AW range, no wrap logic). Data is not modified.
- The block has no internal queue; the requester holds its command while waiting.

## Timing
- Handshake in cycle T (IDLE):
  - T+1: CMD, mem_en=1.
  - T+2: WAIT, mem_rdata valid.
  - T+3: IDLE, rsp_valid=1.
- The next handshake may occur in T+3, the same cycle as the response. This gives peak throughput of one access per 3 cycles and a fixed 3-cycle request-to-response latency.
- cpu_stall is 1 in every cycle where req0_valid=1 and req0 is not being accepted, including cycles lost to requester 1.
- Read-after-write to the same address from either port returns the new data; accesses are strictly serialized.
- Reset asserted (reset=0), any time including mid-transaction:
  - State to IDLE; last_grant to 1.
  - mem_en, mem_we, rspi_valid, busy, readys all go to 0.
  - mem_addr, mem_wdata, rspi_rdata go to 0.
  - In-flight transaction is dropped; no response is ever issued for it.
- First handshake is possible in the first rising edge after reset deasserts.

## Test plan
- Single read: memory[0x10]=0xA5; req0 read addr 0x10 at T -> req0_ready=1 at T, mem_en=1/mem_addr=0x10 at T+1, rsp0_valid=1 with rsp0_rdata=0xA5 at T+3, cpu_stall=0 at T.
- Write then read: req1 write 0x3C to addr 0xFF, then req1 read 0xFF -> second handshake at T+3, rsp1_valid pulses at T+3 (rdata 0) and T+6 (rdata 0x3C).
- Contention: both valid continuously after reset -> grants alternate 0,1,0,1 every 3 cycles; cpu_stall=1 exactly in the IDLE cycles where req1 wins and in all CMD/WAIT cycles.
- Single requester streaming: req0 valid for 4 back-to-back reads -> accepted at T, T+3, T+6, T+9; pointer does not block repeated grants to requester 0.
- Withdrawn request: req1 valid for one cycle while state=CMD, then dropped -> no req1 handshake, no rsp1_valid, mem_en only for req0's access.
- Reset mid-operation: assert reset during WAIT of a req0 read -> all outputs 0 immediately; after release, no rsp0_valid appears; the next tie grants requester 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and three-state sequencer sharing a single-port data memory
// between the EX-stage load/store port (requester 0) and a loader/debug port (requester 1).
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          id_q, id_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic win0_s, win1_s, ready0_s, ready1_s, hs_s;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        win0_s   = req0_valid & (~req1_valid | last_grant_q);
        win1_s   = req1_valid & (~req0_valid | ~last_grant_q);
        ready0_s = (state_q == S_IDLE) & reset & win0_s;
        ready1_s = (state_q == S_IDLE) & reset & win1_s;
        hs_s     = ready0_s | ready1_s;
    end

    // Sequencer next-state: capture on handshake, strobe memory, collect read data.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp0_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_valid_d = 1'b0;
        rsp1_rdata_d = rsp1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    state_d      = S_CMD;
                    last_grant_d = ready1_s;
                    id_d         = ready1_s;
                    mem_en_d     = 1'b1;
                    mem_we_d     = ready1_s ? req1_we    : req0_we;
                    mem_addr_d   = ready1_s ? req1_addr  : req0_addr;
                    mem_wdata_d  = ready1_s ? req1_wdata : req0_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                mem_en_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_IDLE;
                if (id_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_rdata_d = mem_we_q ? {DW{1'b0}} : mem_rdata;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_rdata_d = mem_we_q ? {DW{1'b0}} : mem_rdata;
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any in-flight access without a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {AW{1'b0}};
            mem_wdata_q  <= {DW{1'b0}};
            rsp0_valid_q <= 1'b0;
            rsp0_rdata_q <= {DW{1'b0}};
            rsp1_valid_q <= 1'b0;
            rsp1_rdata_q <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign cpu_stall  = req0_valid & ~ready0_s;
    assign busy       = (state_q != S_IDLE);
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 synchronous memory.
module tb_dmem_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_we, req0_ready;
    logic [7:0] req0_addr, req0_wdata;
    logic       req1_valid, req1_we, req1_ready;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       cpu_stall, busy;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    bit         pend = 1'b0;
    bit         pend_id = 1'b0;
    logic [7:0] pend_exp = 8'h00;

    dmem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the response owed by the previous access (called in its T+3 cycle).
    task automatic check_pend();
        if (pend) begin
            chk("rsp_valid_own", 32'(pend_id ? rsp1_valid : rsp0_valid), 32'd1);
            chk("rsp_rdata_own", 32'(pend_id ? rsp1_rdata : rsp0_rdata), 32'(pend_exp));
            chk("rsp_valid_other", 32'(pend_id ? rsp0_valid : rsp1_valid), 32'd0);
        end else begin
            chk("rsp0_valid_idle", 32'(rsp0_valid), 32'd0);
            chk("rsp1_valid_idle", 32'(rsp1_valid), 32'd0);
        end
        pend = 1'b0;
    endtask

    // One access by a single requester; returns entering T+3 with the response pending.
    task automatic run_access(input bit id, input bit we, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] exp, input bit poke);
        req0_valid = ~id; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        req1_valid = id;  req1_we = we; req1_addr = addr; req1_wdata = wdata;
        @(negedge clk);
        check_pend();
        chk("ready_own", 32'(id ? req1_ready : req0_ready), 32'd1);
        chk("ready_other", 32'(id ? req0_ready : req1_ready), 32'd0);
        chk("stall_at_hs", 32'(cpu_stall), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = ~addr; req1_addr = ~addr; req0_wdata = ~wdata; req1_wdata = ~wdata;
        if (poke) begin
            req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h77;
        end
        @(negedge clk);
        chk("cmd_mem_en", 32'(mem_en), 32'd1);
        chk("cmd_mem_we", 32'(mem_we), 32'(we));
        chk("cmd_mem_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("cmd_mem_wdata", 32'(mem_wdata), 32'(wdata));
        chk("cmd_busy", 32'(busy), 32'd1);
        chk("cmd_rsp_quiet", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        if (poke) chk("poke_ready1", 32'(req1_ready), 32'd0);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("wait_mem_en", 32'(mem_en), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        step();
        pend = 1'b1; pend_id = id; pend_exp = we ? 8'h00 : exp;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
        chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}), 32'd0);
        step();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

        // Preload, single read, write-then-read back to back on port 1.
        run_access(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        run_access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
        run_access(1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b0);
        run_access(1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0);
        // Requester 0 streaming, with a withdrawn requester-1 pulse during one CMD.
        run_access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
        run_access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b1);
        run_access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
        run_access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0);
        @(negedge clk);
        check_pend();
        step();
        @(negedge clk);
        chk("pulse_one_cycle", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        chk("rdata0_held", 32'(rsp0_rdata), 32'h3C);
        chk("rdata1_held", 32'(rsp1_rdata), 32'h3C);

        // Reset during WAIT of a requester-0 read.
        step();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
        @(negedge clk);
        chk("mid_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        #2;
        reset = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'hFF;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_rdata0", 32'(rsp0_rdata), 32'd0);
        chk("mid_rdata1", 32'(rsp1_rdata), 32'd0);
        chk("mid_readys", 32'({req0_ready, req1_ready}), 32'd0);
        chk("mid_stall", 32'(cpu_stall), 32'd1);
        step();
        reset = 1'b1;

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        for (int k = 0; k < 13; k++) begin
            bit idle, g, pg;
            idle = (k % 3) == 0;
            g    = ((k / 3) % 2) == 1;
            pg   = (((k / 3) + 1) % 2) == 1;
            @(negedge clk);
            chk("cont_ready0", 32'(req0_ready), 32'(idle && !g));
            chk("cont_ready1", 32'(req1_ready), 32'(idle && g));
            chk("cont_stall", 32'(cpu_stall), 32'(!(idle && !g)));
            chk("cont_mem_en", 32'(mem_en), 32'((k % 3) == 1));
            if ((k % 3) == 1) chk("cont_mem_addr", 32'(mem_addr), g ? 32'hFF : 32'h10);
            chk("cont_rsp0", 32'(rsp0_valid), 32'(idle && k >= 3 && !pg));
            chk("cont_rsp1", 32'(rsp1_valid), 32'(idle && k >= 3 && pg));
            if (idle && k >= 3) chk("cont_rdata", 32'(pg ? rsp1_rdata : rsp0_rdata),
                                    pg ? 32'h3C : 32'hA5);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
